// File: rtl/hs32_alu_wb.sv
// HS32 ALU writeback stage: architectural NZCV flag register plus a 2-entry
// in-order register-file write buffer with forwarding lookup and flush.
module hs32_alu_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] r_i,
    input  logic [3:0]  fl_i,
    input  logic [3:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        fl_en_i,
    output logic [3:0]  flags_o,
    input  logic        rf_busy_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_addr_o,
    output logic [31:0] rf_data_o,
    input  logic [3:0]  fwd_addr_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    input  logic        flush_i,
    output logic [1:0]  count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t state, state_next;

    // slot 0 is always the oldest pending entry
    logic [3:0]  addr0, addr1;
    logic [31:0] data0, data1;

    logic accept, push, pop;
    logic hit0, hit1;

    assign ready_o = (state != FULL);
    assign count_o = state;
    assign accept  = valid_i && ready_o && !flush_i;
    assign push    = accept && wb_en_i;
    assign pop     = (state != EMPTY) && !rf_busy_i && !flush_i;

    assign rf_we_o   = pop;
    assign rf_addr_o = pop ? addr0 : '0;
    assign rf_data_o = pop ? data0 : '0;

    // Lookup sees only stored entries, so the draining entry is included and
    // the input being accepted this cycle is not.
    assign hit0       = (state != EMPTY) && (addr0 == fwd_addr_i);
    assign hit1       = (state == FULL) && (addr1 == fwd_addr_i);
    assign fwd_hit_o  = hit0 || hit1;
    assign fwd_data_o = hit1 ? data1 : (hit0 ? data0 : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY:   if (push) state_next = ONE;
                ONE:     if (push && !pop) state_next = FULL;
                         else if (!push && pop) state_next = EMPTY;
                FULL:    if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr0 <= '0;
            data0 <= '0;
            addr1 <= '0;
            data1 <= '0;
        end else if (!flush_i) begin
            // push only happens when not FULL, so a pop+push lands in slot 0
            if (pop) begin
                if (push) begin
                    addr0 <= rd_i;
                    data0 <= r_i;
                end else begin
                    addr0 <= addr1;
                    data0 <= data1;
                end
            end else if (push) begin
                if (state == EMPTY) begin
                    addr0 <= rd_i;
                    data0 <= r_i;
                end else begin
                    addr1 <= rd_i;
                    data1 <= r_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_o <= '0;
        end else if (accept && fl_en_i) begin
            flags_o <= fl_i;
        end
    end

endmodule
